// File: rtl/riscv_cache_types_pkg.sv
// Shared cache-hierarchy types: L2<->L3 request/response payloads and arbiter defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_cache_types_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic                we;
        logic [DATA_W/8-1:0] be;
        logic [DATA_W-1:0]   wdata;
    } memory_req_t;

    // One response beat; a burst ends on the beat with last set.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic              error;
    } memory_rsp_t;

    localparam int DEFAULT_L3_ARB_NUM_REQ = 4;
    localparam int DEFAULT_L3_ARB_TIMEOUT = 1024;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set bit of req_i searching upward from ptr_i, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is consumed.
// Ports: req_i request vector, ptr_i search start, gnt_o one-hot grant,
//        gnt_idx_o grant index, any_gnt_o set when some request is granted.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             any_gnt_o
);

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_gnt_o = 1'b0;
        // The first hit in rotation order wins; later hits are ignored.
        for (int k = 0; k < N; k++) begin
            if (!any_gnt_o && req_i[(int'(ptr_i) + k) % N]) begin
                any_gnt_o = 1'b1;
                gnt_idx_o = IDX_W'((int'(ptr_i) + k) % N);
            end
        end
        if (any_gnt_o) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/l3_request_arbiter.sv
// Shares the L3 slave port between NUM_REQ L2 caches, one outstanding transaction, round-robin.
// Latency: grant same cycle as valid; L3 request 1 cycle after the L2 handshake; responses pass through with 0 latency.
// Backpressure: L3 request held until l3_req_ready_i; response beats stall on the owner's l2_rsp_ready_i.
// Ports: l2_req_* per-requester request side, l2_rsp_* response side (payload broadcast,
//        valid only to the owner), l3_req_*/l3_rsp_* L3 side, owner_o/busy_o/timeout_o status.
module l3_request_arbiter
    import riscv_cache_types_pkg::*;
#(
    parameter int NUM_REQ        = DEFAULT_L3_ARB_NUM_REQ,
    parameter int TIMEOUT_CYCLES = DEFAULT_L3_ARB_TIMEOUT,
    parameter int TO_CNT_W       = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_REQ-1:0]         l2_req_valid_i,
    output logic [NUM_REQ-1:0]         l2_req_ready_o,
    input  memory_req_t [NUM_REQ-1:0]  l2_req_i,
    output logic [NUM_REQ-1:0]         l2_rsp_valid_o,
    input  logic [NUM_REQ-1:0]         l2_rsp_ready_i,
    output memory_rsp_t                l2_rsp_o,
    output logic                       l3_req_valid_o,
    input  logic                       l3_req_ready_i,
    output memory_req_t                l3_req_o,
    input  logic                       l3_rsp_valid_i,
    output logic                       l3_rsp_ready_o,
    input  memory_rsp_t                l3_rsp_i,
    output logic [$clog2(NUM_REQ)-1:0] owner_o,
    output logic                       busy_o,
    output logic                       timeout_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    // A disabled watchdog still needs a 1-bit counter to keep widths legal.
    localparam int WD_W  = (TO_CNT_W < 1) ? 1 : TO_CNT_W;
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam memory_rsp_t ERR_BEAT = '{data: '0, last: 1'b1, error: 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RSP,
        S_ERR_RSP,
        S_DRAIN
    } arb_state_e;

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    memory_req_t       req_q, req_d;

    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               any_gnt;
    logic               idle_active;
    logic               l2_hs;
    logic               rsp_hs;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req_i     (l2_req_valid_i),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_gnt_o (any_gnt)
    );

    // The grant is combinational on valids, so it must also be masked while
    // reset is held, otherwise a requester could see ready during reset.
    assign idle_active    = (state_q == S_IDLE) && rst_ni;
    assign l2_req_ready_o = idle_active ? gnt : '0;
    assign l2_hs          = idle_active && any_gnt;
    assign rsp_hs         = l3_rsp_valid_i && l3_rsp_ready_o;

    assign l3_req_valid_o = (state_q == S_ISSUE);
    assign l3_req_o       = req_q;
    assign owner_o        = owner_q;
    assign busy_o         = (state_q != S_IDLE);

    // Response routing towards the owner.
    always_comb begin
        l2_rsp_valid_o = '0;
        l2_rsp_o       = l3_rsp_i;
        l3_rsp_ready_o = 1'b0;
        case (state_q)
            S_WAIT_RSP: begin
                l2_rsp_valid_o[owner_q] = l3_rsp_valid_i;
                l3_rsp_ready_o          = l2_rsp_ready_i[owner_q];
            end
            S_ERR_RSP: begin
                l2_rsp_valid_o[owner_q] = 1'b1;
                l2_rsp_o                = ERR_BEAT;
            end
            S_DRAIN: begin
                // Late beats of the abandoned burst are swallowed here.
                l3_rsp_ready_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        wd_d      = wd_q;
        req_d     = req_q;
        timeout_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (l2_hs) begin
                    req_d    = l2_req_i[gnt_idx];
                    owner_d  = gnt_idx;
                    rr_ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (l3_req_ready_i) begin
                    wd_d    = '0;
                    state_d = S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                // A beat accepted in the expiry cycle takes priority over the timeout.
                if (rsp_hs) begin
                    wd_d = '0;
                    if (l3_rsp_i.last) begin
                        state_d = S_IDLE;
                    end
                end else if ((TIMEOUT_CYCLES != 0) && (wd_q == WD_LAST)) begin
                    wd_d      = WD_MAX;
                    timeout_o = 1'b1;
                    state_d   = S_ERR_RSP;
                end else if (wd_q != WD_MAX) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_ERR_RSP: begin
                if (l2_rsp_ready_i[owner_q]) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (l3_rsp_valid_i && l3_rsp_i.last) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            wd_q     <= '0;
            req_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            wd_q     <= wd_d;
            req_q    <= req_d;
        end
    end

endmodule
